// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit stream blocks.
//   rx_state_t     : receiver FSM state encoding
//   DATA_BITS      : payload bits per frame (8N1)
//   half_bit_count : counter load that lands the first sample mid start bit
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int half_bit_count(input int clks_per_bit);
    return (clks_per_bit / 2) - 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO, valid/ready on both sides.
//   clk, rst_n            : clock, async active-low reset
//   in_data/valid/ready   : write side; in_ready stays high when full if a pop
//                           happens in the same cycle
//   out_data/valid/ready  : read side; out_data is the head byte, 0 when empty
//   level                 : bytes stored, 0 .. 2**AW
module stream_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_cnt;
  logic [AW:0]   rd_cnt;
  logic          full;
  logic          push;
  logic          pop;

  // Counters carry one extra bit so full and empty are distinguishable;
  // their low bits are the memory pointers.
  assign level     = wr_cnt - rd_cnt;
  assign full      = (level == DEPTH);
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;
  assign out_data  = out_valid ? mem[rd_cnt[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (push) wr_cnt <= wr_cnt + 1'b1;
      if (pop)  rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_cnt[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver feeding a byte FIFO (valid/ready stream).
//   i_clk, i_rst     : clock, async active-low reset
//   i_uart_rx        : raw serial line, idle high, asynchronous
//   o_data, o_valid  : head of FIFO; i_ready pops it
//   o_fifo_level     : bytes buffered
//   o_err_frame      : 1-cycle pulse on a low stop bit
//   o_err_overrun    : 1-cycle pulse when a byte is dropped on a full FIFO
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | counting to mid start bit; high there means a glitch
// DATA   | sampling 8 data bits LSB first, one per bit period
// STOP   | sampling the stop bit; high pushes the byte
// BREAK  | stop bit was low, wait for the line to return high
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_uart_rx,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [FIFO_AW:0] o_fifo_level,
  output logic             o_err_frame,
  output logic             o_err_overrun
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(half_bit_count(CLKS_PER_BIT));
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 push_q, push_nxt;
  logic                 frame_nxt;
  logic                 err_frame_q;
  logic                 err_overrun_q;
  logic                 fifo_in_ready;

  // Presetting to 1 keeps reset release from looking like a start bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      push_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= bit_nxt;
      shift         <= shift_nxt;
      push_q        <= push_nxt;
      err_frame_q   <= frame_nxt;
      err_overrun_q <= push_q && !fifo_in_ready;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    push_nxt  = 1'b0;
    frame_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = HALF_CNT;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DATA;
            cnt_nxt   = FULL_CNT;
            bit_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          cnt_nxt   = FULL_CNT;
          if (bit_idx == LAST_BIT) state_nxt = ST_STOP;
          else                     bit_nxt   = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            frame_nxt = 1'b1;
            state_nxt = ST_BREAK;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // shift only changes in DATA, so it still holds the byte while push_q is high.
  stream_fifo #(
    .DW (DATA_BITS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .in_data   (shift),
    .in_valid  (push_q),
    .in_ready  (fifo_in_ready),
    .out_data  (o_data),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .level     (o_fifo_level)
  );

  assign o_err_frame   = err_frame_q;
  assign o_err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
module tb_uart_rx_stream;

  localparam int CPB   = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [7:0]    o_data;
  logic          o_valid;
  logic [AW:0]   o_fifo_level;
  logic          o_err_frame;
  logic          o_err_overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stop_mid_cyc = 0;
  event ev_stop_mid;

  // observation state, written only by the monitor
  logic [7:0] got[$];
  int n_frame = 0;
  int n_over = 0;
  int n_both = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;

  uart_rx_stream #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_uart_rx     (rx),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (ready),
    .o_fifo_level  (o_fifo_level),
    .o_err_frame   (o_err_frame),
    .o_err_overrun (o_err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && ready) got.push_back(o_data);
      if (o_err_frame) n_frame++;
      if (o_err_overrun) n_over++;
      if (o_err_frame && o_err_overrun) n_both++;
      if (o_valid && !prev_valid) rise_cyc = cyc;
    end
    prev_valid = o_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB / 2) @(posedge clk);
    #1;
    stop_mid_cyc = cyc;
    -> ev_stop_mid;
    repeat (CPB - CPB / 2) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int n, input int limit);
    for (int i = 0; i < limit && got.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
    checks++; if (o_fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", o_fifo_level); end
    checks++; if (o_err_frame !== 1'b0 || o_err_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_errs: got frame=%b overrun=%b want 0 0", o_err_frame, o_err_overrun);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    logic [7:0] b;
    int base, f0, o0, lat;
    ready = 1'b1;
    base = got.size(); f0 = n_frame; o0 = n_over;
    send_frame(8'hA5, 1'b1);
    wait_got(base + 1, 40);
    lat = rise_cyc - stop_mid_cyc;
    checks++; if (got.size() != base + 1) begin
      errors++; $display("FAIL single_count: got %0d beats want 1", got.size() - base);
    end else if (got[base] !== 8'hA5) begin
      errors++; $display("FAIL single_data: got %h want a5", got[base]);
    end
    checks++; if (lat < 4 || lat > 5) begin errors++; $display("FAIL single_latency: got %0d cycles want 4..5", lat); end
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      exp.push_back(b);
      send_frame(b, 1'b1);
    end
    wait_got(base + 6, 100);
    checks++; if (got.size() != base + 6) begin
      errors++; $display("FAIL random_count: got %0d beats want 6", got.size() - base);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (got[base + 1 + k] !== exp[k]) begin
          errors++; $display("FAIL random_data[%0d]: got %h want %h", k, got[base + 1 + k], exp[k]);
        end
      end
    end
    checks++; if (n_frame != f0 || n_over != o0) begin
      errors++; $display("FAIL single_errs: got frame=%0d overrun=%0d want 0 0", n_frame - f0, n_over - o0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] model[$];
    int exp_over, base, o0;
    bit stable;
    ready = 1'b0;
    exp_over = 0; base = got.size(); o0 = n_over;
    for (int k = 1; k <= 6; k++) begin
      send_frame(8'(k), 1'b1);
      if (model.size() < DEPTH) model.push_back(8'(k));
      else exp_over++;
    end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (o_fifo_level !== 3'(model.size())) begin
      errors++; $display("FAIL overrun_level: got %0d want %0d", o_fifo_level, model.size());
    end
    checks++; if (n_over - o0 != exp_over) begin
      errors++; $display("FAIL overrun_pulses: got %0d want %0d", n_over - o0, exp_over);
    end
    stable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b1 || o_data !== model[0]) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL backpressure_hold: got valid=%b data=%h want 1 %h", o_valid, o_data, model[0]); end
    ready = 1'b1;
    wait_got(base + model.size(), 20);
    checks++; if (got.size() != base + model.size()) begin
      errors++; $display("FAIL drain_count: got %0d want %0d", got.size() - base, model.size());
    end else begin
      for (int k = 0; k < model.size(); k++) begin
        checks++; if (got[base + k] !== model[k]) begin
          errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, got[base + k], model[k]);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_fifo_level !== '0) begin errors++; $display("FAIL drain_level: got %0d want 0", o_fifo_level); end
  endtask

  task automatic test_framing();
    int base, f0, o0;
    ready = 1'b1;
    base = got.size(); f0 = n_frame; o0 = n_over;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    send_frame(8'h7E, 1'b1);
    wait_got(base + 1, 40);
    checks++; if (n_frame - f0 != 1) begin errors++; $display("FAIL frame_pulses: got %0d want 1", n_frame - f0); end
    checks++; if (got.size() != base + 1) begin
      errors++; $display("FAIL frame_count: got %0d beats want 1", got.size() - base);
    end else if (got[base] !== 8'h7E) begin
      errors++; $display("FAIL frame_data: got %h want 7e", got[base]);
    end
    checks++; if (n_over != o0) begin errors++; $display("FAIL frame_overrun: got %0d want 0", n_over - o0); end
  endtask

  task automatic test_glitch();
    int base, f0, o0;
    logic [7:0] b;
    ready = 1'b1;
    base = got.size(); f0 = n_frame; o0 = n_over;
    rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    checks++; if (got.size() != base || o_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_output: got %0d beats valid=%b want 0 0", got.size() - base, o_valid);
    end
    checks++; if (n_frame != f0 || n_over != o0) begin
      errors++; $display("FAIL glitch_errs: got frame=%0d overrun=%0d want 0 0", n_frame - f0, n_over - o0);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    wait_got(base + 1, 40);
    checks++; if (got.size() != base + 1) begin
      errors++; $display("FAIL glitch_recover_count: got %0d want 1", got.size() - base);
    end else if (got[base] !== b) begin
      errors++; $display("FAIL glitch_recover_data: got %h want %h", got[base], b);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] model[$];
    logic [7:0] b;
    int base, o0;
    ready = 1'b0;
    base = got.size(); o0 = n_over;
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      model.push_back(b);
      send_frame(b, 1'b1);
    end
    checks++; if (o_fifo_level !== 3'(DEPTH)) begin errors++; $display("FAIL fullpop_prefill: got %0d want %0d", o_fifo_level, DEPTH); end
    model.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(ev_stop_mid);
        // the byte lands in the FIFO 4 edges after the stop midpoint
        repeat (3) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (o_fifo_level !== 3'(DEPTH)) begin
          errors++; $display("FAIL fullpop_level: got %0d want %0d", o_fifo_level, DEPTH);
        end
      end
    join
    wait_got(base + model.size(), 40);
    checks++; if (n_over != o0) begin errors++; $display("FAIL fullpop_overrun: got %0d want 0", n_over - o0); end
    checks++; if (got.size() != base + model.size()) begin
      errors++; $display("FAIL fullpop_count: got %0d want %0d", got.size() - base, model.size());
    end else begin
      for (int k = 0; k < model.size(); k++) begin
        checks++; if (got[base + k] !== model[k]) begin
          errors++; $display("FAIL fullpop_data[%0d]: got %h want %h", k, got[base + k], model[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, f0;
    ready = 1'b0;
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    checks++; if (o_fifo_level !== 3'd2) begin errors++; $display("FAIL rstmid_prefill: got %0d want 2", o_fifo_level); end
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_fifo_level !== '0) begin
          errors++; $display("FAIL rstmid_clear: got valid=%b level=%0d want 0 0", o_valid, o_fifo_level);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    ready = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    base = got.size(); f0 = n_frame;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got valid=%b want 0", o_valid); end
    send_frame(8'h12, 1'b1);
    wait_got(base + 1, 40);
    checks++; if (got.size() != base + 1) begin
      errors++; $display("FAIL rstmid_count: got %0d want 1", got.size() - base);
    end else if (got[base] !== 8'h12) begin
      errors++; $display("FAIL rstmid_data: got %h want 12", got[base]);
    end
    checks++; if (n_frame != f0) begin errors++; $display("FAIL rstmid_frame: got %0d want 0", n_frame - f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_framing();
    test_glitch();
    test_full_pop();
    test_reset_mid();
    checks++; if (n_both != 0) begin errors++; $display("FAIL pulse_overlap: got %0d want 0", n_both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
